// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_scan_ctrl
//  Purpose  : Scans a parallel word through a bit-serial "101" Mealy detector.
//             On an accepted start, the word and shift order are latched.
//             The detector is then cleared for one cycle. Next, the word is
//             shifted out one bit per clock while same-cycle detect pulses are
//             counted, and finally a one-cycle done pulse is raised.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous reset, active low
//             start      - scan request, honoured only in IDLE
//             data_in    - word to scan, latched on accepted start
//             msb_first  - shift order, latched with data_in
//             busy       - high from CLEAR through DONE
//             done       - one-cycle pulse in DONE
//             found      - match_cnt is nonzero
//             match_cnt  - detect pulses seen during SHIFT
//             first_pos  - shift index of the first detect pulse (0 if none)
//             det_rst    - detector reset, high only in CLEAR
//             det_din    - serial bit to detector, 0 outside SHIFT
//             det_detect - detector Mealy output, combinational on det_din
//  Revision : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] first_pos,
    output logic             det_rst,
    output logic             det_din,
    input  logic             det_detect
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic             msb_q,   msb_d;
    logic [CNT_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] pos_q,   pos_d;

    // Bit currently presented to the detector; the register shifts toward
    // whichever end was selected, so the live bit is always at that end.
    logic cur_bit;
    assign cur_bit = msb_q ? sreg_q[WIDTH-1] : sreg_q[0];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            msb_q   <= msb_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        msb_d   = msb_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    sreg_d  = data_in;
                    msb_d   = msb_first;
                    idx_d   = '0;
                    cnt_d   = '0;
                    pos_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
                idx_d   = '0;
            end
            S_SHIFT: begin
                if (det_detect) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Zero count means no earlier hit in this scan
                    if (cnt_q == '0) begin
                        pos_d = idx_q;
                    end
                end
                sreg_d = msb_q ? {sreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg_q[WIDTH-1:1]};
                idx_d  = idx_q + CNT_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        det_rst   = (state_q == S_CLEAR);
        det_din   = (state_q == S_SHIFT) ? cur_bit : 1'b0;
        found     = (cnt_q != '0);
        match_cnt = cnt_q;
        first_pos = pos_q;
    end

endmodule
`default_nettype wire

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Controller that sequences the serial "101" Mealy sequence detector over a parallel word.
- Latches a WIDTH-bit word on a start handshake, then clears the detector.
- Shifts the word one bit per clock onto the detector's serial input and collects its same-cycle detect pulses.
- Reports match count, first-match position and completion.
- Sits between a parallel producer (register or CPU-side logic) and the bit-serial detector.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
CNT_W, 6, width of count and position outputs; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
start  input  1  request to scan data_in; sampled only in IDLE.
data_in  input  WIDTH  word to scan; latched on the accepted start.
msb_first  input  1  shift order; latched with data_in (1 = bit WIDTH-1 first, 0 = bit 0 first).
busy  output  1  high from the cycle after an accepted start through the DONE cycle.
done  output  1  one-cycle pulse in DONE.
found  output  1  1 if match_cnt is nonzero.
match_cnt  output  CNT_W  number of detect pulses seen during SHIFT.
first_pos  output  CNT_W  shift index (0..WIDTH-1) of the first detect pulse; 0 if none.
det_rst  output  1  active-high reset to the detector; high only in CLEAR.
det_din  output  1  serial bit to the detector.
det_detect  input  1  Mealy detect from the detector; combinational on det_din.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state = IDLE; busy = 0, done = 0, found = 0.
  - match_cnt = 0, first_pos = 0.
  - det_rst = 0, det_din = 0.
  - Internal shift register and index = 0.
- States and transitions:
  - IDLE: start=1 → CLEAR; latch data_in and msb_first into internal registers; clear match_cnt, first_pos and found.
  - CLEAR (1 cycle): det_rst=1, det_din=0 → SHIFT with idx=0.
  - SHIFT (exactly WIDTH cycles): det_din = current bit (MSB or LSB of the shift register, per latched order).
    - det_detect is sampled in the same cycle det_din is driven.
    - If det_detect=1: match_cnt += 1; if this is the first hit, first_pos = idx.
    - Each cycle: shift the register, idx += 1.
    - After idx = WIDTH-1 → DONE.
  - DONE (1 cycle): done=1, det_din=0 → IDLE.
- Latency: start accepted at edge N → CLEAR in cycle N+1 → SHIFT in cycles N+2..N+WIDTH+1 → done high in cycle N+WIDTH+2.
- Result hold: match_cnt, first_pos and found are updated live during SHIFT. They hold from DONE until the next accepted start.
- Handshake rules:
  - start while busy=1 is ignored, with no effect on the latched word.
  - start held high continuously re-triggers on each return to IDLE, giving one idle cycle between scans.
- Input changes: data_in and msb_first changes after the accept cycle have no effect on the current scan.
- det_detect outside SHIFT is ignored.
- det_din is 0 in every state except SHIFT.
- Counting: match_cnt cannot exceed WIDTH, so there is no wrap. No saturation logic is required given the CNT_W constraint.
- Overlapping matches are whatever the detector reports. The controller counts pulses and does not interpret them.
- Reset mid-scan: immediate return to IDLE with all outputs at reset values. The partial result is discarded and there is no done pulse.

Test Plan:
(The bench instantiates this block with an overlapping "101" Mealy detector model; WIDTH=8.)
1. data_in=8'b1010_1000, msb_first=1, start pulse → serial 1,0,1,0,1,0,0,0; done 10 cycles after start edge; match_cnt=2, first_pos=2, found=1.
2. data_in=8'b0000_0101, msb_first=0 → serial 1,0,1,0,0,0,0,0; match_cnt=1, first_pos=2, found=1.
3. data_in=8'h00 then 8'hFF → both give match_cnt=0, first_pos=0, found=0, done still pulses once each.
4. Start the scan of case 1, then raise start again with data_in=8'h00 during SHIFT → ignored; result is still match_cnt=2; busy stays high through DONE.
5. Start the scan of case 1; drive rst=0 during the 3rd SHIFT cycle → busy, done, match_cnt, det_din go to 0 asynchronously; after release, a fresh scan gives correct results.
6. start held high across two scans (8'b1010_1010 then unchanged) → two done pulses 11 cycles apart; match_cnt=3 each time; det_rst high exactly one cycle before each SHIFT run.
